mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Arbiter and sequencer for the single byte-wide, synchronous-read main RAM shared by the instruction-fetch stage and the memory-access stage. It accepts 32-bit word fetches from IF and byte/half/word loads and stores from MEM, serialises them into little-endian byte cycles on the RAM port, and returns assembled data with a one-cycle done pulse.

## Interface
- No parameters; bus widths are fixed: address/data 32 bits, RAM data 8 bits.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF fetch request, held until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle pulse, if_data valid this cycle
- if_data  out  32  fetched instruction word
- mem_req  in  1  MEM access request, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  00 byte, 01 half, 11 word; 10 treated as word
- mem_addr  in  32  access byte address
- mem_wdata  in  32  store data, low bytes used
- mem_done  out  1  one-cycle pulse, mem_rdata valid this cycle (loads)
- mem_rdata  out  32  load data, zero-extended; sign extension is done by MEM
- flush  in  1  pipeline flush (used only with MEMCTRL_FLUSH_EN)
- ram_a  out  32  RAM byte address
- ram_dout  out  8  RAM write data
- ram_wr  out  1  RAM write enable
- ram_din  in  8  RAM read data, valid one cycle after address

## Operation
- States: IDLE, READ, WRITE. Byte count n = 1, 2 or 4 (IF always 4).
- IDLE: if mem_req, latch MEM request; else if if_req, latch IF request. mem_req wins on simultaneous requests (older instruction first). Load/fetch -> READ, store -> WRITE.
- IDLE does not sample requests in the cycle where if_done or mem_done is high; the requester deasserts req in that cycle or it is taken as a new request next cycle.
- READ: drive ram_a = addr+i for i = 0..n-1 on consecutive cycles, ram_wr=0; capture ram_din one cycle later into byte i of the result (little-endian). After the last capture return to IDLE and pulse the owner's done.
- WRITE: drive ram_a = addr+i, ram_dout = wdata byte i, ram_wr=1 for i = 0..n-1; then return to IDLE and pulse mem_done.
- Unfetched upper bytes of mem_rdata are 0. if_data/mem_rdata hold their value until the next completion of the same requester.
- Address arithmetic is 32-bit, wraps modulo 2^32 (0xFFFFFFFF+1 = 0).
- Reset: state IDLE, ram_a=0, ram_dout=0, ram_wr=0, if_done=0, mem_done=0, if_data=0, mem_rdata=0. Reset mid-transaction abandons it with no done pulse; partially written bytes remain in RAM.
- ram_a=0 and ram_wr=0 whenever IDLE.

## Timing
- Request sampled in IDLE at cycle c0; first ram_a at c1.
- Read of n bytes: ram_a at c1..cn, data captured c2..c(n+1), done and data at c(n+2). Word fetch: c0 -> if_done at c6.
- Write of n bytes: ram_wr high c1..cn, mem_done at c(n+1). Word store: done at c5.
- Back-to-back: earliest next sample is the cycle after a done pulse.
- Requests changing while not in IDLE are ignored; latched address/data/len are used.

## Configuration
- MEMCTRL_FLUSH_EN defined: flush=1 while an IF read is in progress aborts it; state IDLE next cycle, ram_a=0, no if_done. flush=1 in IDLE suppresses sampling of if_req that cycle (mem_req still sampled). MEM transactions are never aborted.
- Undefined: flush ignored; IF reads always complete and pulse if_done; IF discards stale data.

## Test plan
- Fetch 0x1000, RAM bytes 13,05,00,00 -> ram_a 0x1000..0x1003 at c1..c4, if_done at c6, if_data=0x00000513.
- if_req and mem_req (word load 0x2000) high at c0 -> mem served first, mem_done at c6; IF fetch sampled at c7, if_done at c13.
- Store half 0xDEADBEEF, len 01 to 0x20 -> ram_wr with (0x20,EF), (0x21,BE) at c1,c2; mem_done at c3.
- Load byte from 0x31 holding 0x80 -> mem_done at c3, mem_rdata=0x00000080.
- With MEMCTRL_FLUSH_EN: fetch started c0, flush at c3 -> IDLE at c4, no if_done; without macro if_done at c6.
- rst at c2 of a word store -> all outputs 0 at c3, no mem_done; fresh request afterwards completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial arbiter/sequencer between IF fetches, MEM loads/stores and a byte-wide synchronous-read RAM.
// Optional MEMCTRL_FLUSH_EN: flush aborts in-flight IF reads and blocks IF sampling in IDLE.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  input  logic        flush,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state, state_nx;
  logic [31:0] addr, wdata, rbuf, rdata_fin;
  logic [2:0]  cnt, nbytes, mem_n;
  logic [1:0]  bidx;
  logic        own_mem, take_mem, take_if, abort, if_block;

`ifdef MEMCTRL_FLUSH_EN
  assign if_block = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign if_block     = 1'b0;
`endif

  always_comb begin
    case (mem_len)
      2'b00:   mem_n = 3'd1;
      2'b01:   mem_n = 3'd2;
      default: mem_n = 3'd4;
    endcase
  end

  // In READ, cnt is the byte whose address is on ram_a; byte cnt-1 arrives on ram_din.
  always_comb begin
    state_nx  = state;
    take_mem  = 1'b0;
    take_if   = 1'b0;
    abort     = 1'b0;
    ram_a     = '0;
    ram_dout  = '0;
    ram_wr    = 1'b0;
    bidx      = 2'(cnt - 3'd1);
    rdata_fin = rbuf;
    rdata_fin[{bidx, 3'b000} +: 8] = ram_din;
    case (state)
      IDLE: begin
        if (!if_done && !mem_done) begin
          if (mem_req) begin
            take_mem = 1'b1;
            state_nx = mem_we ? WRITE : READ;
          end else if (if_req && !if_block) begin
            take_if  = 1'b1;
            state_nx = READ;
          end
        end
      end
      READ: begin
        abort = if_block && !own_mem;
        if (cnt < nbytes) ram_a = addr + 32'(cnt);
        if (abort || cnt == nbytes) state_nx = IDLE;
      end
      WRITE: begin
        ram_a    = addr + 32'(cnt);
        ram_dout = wdata[{cnt[1:0], 3'b000} +: 8];
        ram_wr   = 1'b1;
        if (cnt + 3'd1 == nbytes) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      nbytes    <= '0;
      addr      <= '0;
      wdata     <= '0;
      rbuf      <= '0;
      own_mem   <= 1'b0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_data   <= '0;
      mem_rdata <= '0;
    end else begin
      state    <= state_nx;
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= '0;
          rbuf <= '0;
          if (take_mem) begin
            addr    <= mem_addr;
            wdata   <= mem_wdata;
            nbytes  <= mem_n;
            own_mem <= 1'b1;
          end else if (take_if) begin
            addr    <= if_addr;
            nbytes  <= 3'd4;
            own_mem <= 1'b0;
          end
        end
        READ: begin
          if (!abort) begin
            cnt <= cnt + 3'd1;
            if (cnt != 3'd0) rbuf[{bidx, 3'b000} +: 8] <= ram_din;
            if (cnt == nbytes) begin
              if (own_mem) begin
                mem_rdata <= rdata_fin;
                mem_done  <= 1'b1;
              end else begin
                if_data <= rdata_fin;
                if_done <= 1'b1;
              end
            end
          end
        end
        WRITE: begin
          cnt <= cnt + 3'd1;
          if (cnt + 3'd1 == nbytes) mem_done <= 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: RAM behavioural model plus transaction-level reference
// (expected bus trace, done cycle and data derived from byte count and request order).
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, if_req, mem_req, mem_we, flush, if_done, mem_done, ram_wr;
  logic [1:0]  mem_len;
  logic [31:0] if_addr, mem_addr, mem_wdata, if_data, mem_rdata, ram_a;
  logic [7:0]  ram_dout, ram_din;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_mem = '0;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .flush(flush),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (ram_wr) ram[ram_a] = ram_dout;
    ram_din <= ram_rd(ram_a);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  function automatic int nb(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  // One transaction (mem, IF, or both issued together); checks every cycle up to the last done.
  task automatic run_txn(input bit do_if, input logic [31:0] ia, input bit do_mem,
                         input bit we, input logic [1:0] len, input logic [31:0] ma,
                         input logic [31:0] wd);
    logic [31:0] ea [0:31];
    logic        ew [0:31];
    logic [7:0]  ed [0:31];
    logic [31:0] exp_m, exp_i;
    int k, mem_t, if_t, last, n;
    for (int i = 0; i < 32; i++) begin ea[i] = '0; ew[i] = 1'b0; ed[i] = '0; end
    k = 0; mem_t = -1; if_t = -1; exp_m = '0; exp_i = '0;
    if (do_mem) begin
      n = nb(len);
      for (int i = 0; i < n; i++) begin
        k++;
        ea[k] = ma + 32'(i);
        ew[k] = we;
        ed[k] = we ? wd[8*i +: 8] : 8'h00;
        if (we) ref_mem[ma + 32'(i)] = wd[8*i +: 8];
        else    exp_m[8*i +: 8] = ref_rd(ma + 32'(i));
      end
      if (!we) k++;
      k++;
      mem_t = k;
    end
    if (do_if) begin
      if (do_mem) k++;
      for (int i = 0; i < 4; i++) begin
        k++;
        ea[k] = ia + 32'(i);
        exp_i[8*i +: 8] = ref_rd(ia + 32'(i));
      end
      k += 2;
      if_t = k;
    end
    last = k;
    @(posedge clk); #1;
    if_req = do_if; if_addr = ia;
    mem_req = do_mem; mem_we = we; mem_len = len; mem_addr = ma; mem_wdata = wd;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      chk("ram_a", ram_a, ea[c]);
      chk("ram_wr", 32'(ram_wr), 32'(ew[c]));
      if (ew[c]) chk("ram_dout", 32'(ram_dout), 32'(ed[c]));
      chk("if_done", 32'(if_done), 32'(c == if_t));
      chk("mem_done", 32'(mem_done), 32'(c == mem_t));
      if (c == mem_t) begin
        if (!we) begin
          chk("mem_rdata", mem_rdata, exp_m);
          last_mem = exp_m;
        end
        mem_req = 1'b0;
      end
      if (c == if_t) begin
        chk("if_data", if_data, exp_i);
        last_if = exp_i;
        if_req = 1'b0;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("if_data_hold", if_data, last_if);
    chk("mem_rdata_hold", mem_rdata, last_mem);
  endtask

  initial begin
    logic [31:0] a, d;
    int kind;
    rst = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; flush = 0;
    mem_len = '0; if_addr = '0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_wr", 32'(ram_wr), 32'h0);
    chk("rst_ram_dout", 32'(ram_dout), 32'h0);
    chk("rst_done", {30'b0, if_done, mem_done}, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;

    poke(32'h1000, 8'h13); poke(32'h1001, 8'h05); poke(32'h1002, 8'h00); poke(32'h1003, 8'h00);
    run_txn(1, 32'h1000, 0, 0, 2'b00, '0, '0);
    chk("fetch_0x1000", if_data, 32'h0000_0513);

    poke(32'h2000, 8'h44); poke(32'h2001, 8'h33); poke(32'h2002, 8'h22); poke(32'h2003, 8'h11);
    run_txn(1, 32'h1000, 1, 0, 2'b11, 32'h2000, '0);
    chk("prio_mem_word", mem_rdata, 32'h1122_3344);

    run_txn(0, '0, 1, 1, 2'b01, 32'h20, 32'hDEAD_BEEF);
    run_txn(0, '0, 1, 0, 2'b01, 32'h20, '0);
    chk("half_readback", mem_rdata, 32'h0000_BEEF);

    poke(32'h31, 8'h80);
    run_txn(0, '0, 1, 0, 2'b00, 32'h31, '0);
    chk("byte_zext", mem_rdata, 32'h0000_0080);

    poke(32'hFFFF_FFFE, 8'hAA); poke(32'hFFFF_FFFF, 8'hBB); poke(32'h0, 8'hCC); poke(32'h1, 8'hDD);
    run_txn(0, '0, 1, 0, 2'b10, 32'hFFFF_FFFE, '0);
    chk("wrap_word", mem_rdata, 32'hDDCC_BBAA);

    // flush while fetching 0x1000
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h1000;
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
`ifdef MEMCTRL_FLUSH_EN
    if_req = 1'b0;
    chk("flush_ram_a", ram_a, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("flush_no_done", 32'(if_done), 32'h0);
    end
`else
    for (int c = 4; c <= 6; c++) begin
      chk("noflush_done", 32'(if_done), 32'(c == 6));
      if (c == 6) begin
        chk("noflush_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    last_if = 32'h0000_0513;
`endif

    // reset during a word store: two bytes reach RAM, no done pulse
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b11; mem_addr = 32'h240; mem_wdata = 32'h8765_4321;
    @(posedge clk); #1;
    chk("rst_mid_c1_done", 32'(mem_done), 32'h0);
    @(posedge clk); #1;
    chk("rst_mid_c2_done", 32'(mem_done), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_req = 1'b0;
    chk("rst_mid_ram_a", ram_a, 32'h0);
    chk("rst_mid_wr", {29'b0, ram_wr, if_done, mem_done}, 32'h0);
    chk("rst_mid_dout", 32'(ram_dout), 32'h0);
    chk("rst_mid_data", if_data | mem_rdata, 32'h0);
    ref_mem[32'h240] = 8'h21; ref_mem[32'h241] = 8'h43;
    last_if = '0; last_mem = '0;
    run_txn(0, '0, 1, 0, 2'b11, 32'h240, '0);
    chk("after_rst_load", mem_rdata, 32'h0000_4321);

    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                      : 32'h200 + $urandom_range(0, 31);
      d = $urandom;
      run_txn(kind == 0 || kind == 2, 32'h200 + $urandom_range(0, 31),
              kind != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
